// File: rtl/lcd_panel_responder_if.sv
// Parallel character-LCD bus: controller (master) drives e/rs/rw/lcd_data, panel (slave) returns read data and busy.
// Pure wiring, no latency; the busy flag is the panel's only backpressure.
interface lcd_panel_responder_if;
    logic       e;
    logic       rs;
    logic       rw;
    logic [7:0] lcd_data;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy_flag;

    modport master (
        output e, rs, rw, lcd_data,
        input  rd_data, rd_valid, busy_flag
    );

    modport slave (
        input  e, rs, rw, lcd_data,
        output rd_data, rd_valid, busy_flag
    );
endinterface

// File: rtl/lcd_panel_responder.sv
// HD44780-style panel model: decodes bus transfers, holds display state, 80-byte DDRAM and busy flag.
// Transfer executes on the e falling edge; all effects are registered one cycle later.
// Backpressure via busy_flag; non-status transfers while busy are dropped and set err. Option: LCD_RSP_SHIFT_EN.
module lcd_panel_responder #(
    parameter int BUSY_SHORT = 40,
    parameter int BUSY_LONG  = 160,
    parameter int E_MIN      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lcd_panel_responder_if.slave  bus,
    output logic [6:0]            ddram_addr,
    output logic                  disp_on,
    output logic                  cursor_on,
    output logic                  blink_on,
    output logic                  entry_id,
    output logic                  entry_s,
    output logic                  func_dl,
    output logic                  func_n,
    output logic                  func_f,
    output logic [5:0]            shift_ofs,
    output logic                  err,
    input  logic [6:0]            dbg_addr,
    output logic [7:0]            dbg_data
);
    localparam int BW  = $clog2(BUSY_LONG + 1);
    localparam int ECW = $clog2(E_MIN + 1);

    logic [7:0]     ddram [0:79];
    logic           e_q, rs_l, rw_l;
    logic [7:0]     data_l;
    logic [ECW-1:0] ecnt;
    logic [BW-1:0]  busy_cnt;
    logic           fill_active;
    logic [6:0]     fill_idx;
    logic [7:0]     rd_data_q;
    logic           rd_valid_q;

    logic           fall, pulse_ok, is_busy, wr_data_ok;
    logic [6:0]     ac_idx;
    logic           mem_we;
    logic [6:0]     mem_a;
    logic [7:0]     mem_d;

    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc, input logic n);
        if (n) begin
            if (inc) return (ac == 7'h27) ? 7'h40 : (ac == 7'h67) ? 7'h00 : ac + 7'd1;
            else     return (ac == 7'h40) ? 7'h27 : (ac == 7'h00) ? 7'h67 : ac - 7'd1;
        end else begin
            if (inc) return (ac == 7'h4F) ? 7'h00 : ac + 7'd1;
            else     return (ac == 7'h00) ? 7'h4F : ac - 7'd1;
        end
    endfunction

    function automatic logic addr_legal(input logic [6:0] a, input logic n);
        if (n) return (a <= 7'h27) || (a >= 7'h40 && a <= 7'h67);
        else   return a <= 7'h4F;
    endfunction

`ifdef LCD_RSP_SHIFT_EN
    function automatic logic [5:0] ofs_step(input logic [5:0] ofs, input logic right);
        if (right) return (ofs == 6'd39) ? 6'd0 : ofs + 6'd1;
        else       return (ofs == 6'd0) ? 6'd39 : ofs - 6'd1;
    endfunction
`endif

    assign fall          = e_q & ~bus.e;
    assign pulse_ok      = (ecnt == ECW'(E_MIN));
    assign is_busy       = (busy_cnt != '0);
    assign bus.busy_flag = is_busy;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign ac_idx        = func_n ? ((ddram_addr[6] ? 7'd40 : 7'd0) + {1'b0, ddram_addr[5:0]}) : ddram_addr;
    assign wr_data_ok    = fall & pulse_ok & ~is_busy & rs_l & ~rw_l;
    assign dbg_data      = (dbg_addr < 7'd80) ? ddram[dbg_addr] : 8'h00;

    // The clear fill owns the write port; bus writes cannot collide since they are refused while busy.
    always_comb begin
        mem_we = 1'b0;
        mem_a  = ac_idx;
        mem_d  = data_l;
        if (fill_active) begin
            mem_we = 1'b1;
            mem_a  = fill_idx;
            mem_d  = 8'h20;
        end else if (wr_data_ok && ac_idx < 7'd80) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) ddram[mem_a] <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q         <= 1'b0;
            rs_l        <= 1'b0;
            rw_l        <= 1'b0;
            data_l      <= 8'h00;
            ecnt        <= '0;
            busy_cnt    <= BW'(BUSY_LONG);
            fill_active <= 1'b1;
            fill_idx    <= 7'd0;
            rd_data_q   <= 8'h00;
            rd_valid_q  <= 1'b0;
            ddram_addr  <= 7'd0;
            disp_on     <= 1'b0;
            cursor_on   <= 1'b0;
            blink_on    <= 1'b0;
            entry_id    <= 1'b1;
            entry_s     <= 1'b0;
            func_dl     <= 1'b0;
            func_n      <= 1'b0;
            func_f      <= 1'b0;
            err         <= 1'b0;
`ifdef LCD_RSP_SHIFT_EN
            shift_ofs   <= 6'd0;
`endif
        end else begin
            e_q        <= bus.e;
            rd_valid_q <= 1'b0;
            if (bus.e) begin
                rs_l   <= bus.rs;
                rw_l   <= bus.rw;
                data_l <= bus.lcd_data;
                if (ecnt != ECW'(E_MIN)) ecnt <= ecnt + 1'b1;
            end else begin
                ecnt <= '0;
            end
            if (is_busy) busy_cnt <= busy_cnt - 1'b1;
            if (fill_active) begin
                fill_idx <= fill_idx + 7'd1;
                if (fill_idx == 7'd79) fill_active <= 1'b0;
            end

            if (fall) begin
                if (!pulse_ok) begin
                    err <= 1'b1;
                end else if (!rs_l && rw_l) begin
                    rd_data_q  <= {is_busy, ddram_addr};
                    rd_valid_q <= 1'b1;
                end else if (is_busy) begin
                    err <= 1'b1;
                end else if (rw_l) begin
                    rd_data_q  <= (ac_idx < 7'd80) ? ddram[ac_idx] : 8'h00;
                    rd_valid_q <= 1'b1;
                    ddram_addr <= ac_step(ddram_addr, entry_id, func_n);
                end else if (rs_l) begin
                    busy_cnt   <= BW'(BUSY_SHORT);
                    ddram_addr <= ac_step(ddram_addr, entry_id, func_n);
`ifdef LCD_RSP_SHIFT_EN
                    // Incrementing entry with S=1 scrolls the display left, so the offset drops.
                    if (entry_s) shift_ofs <= ofs_step(shift_ofs, ~entry_id);
`endif
                end else begin
                    busy_cnt <= BW'(BUSY_SHORT);
                    casez (data_l)
                        8'b1???????: begin
                            if (addr_legal(data_l[6:0], func_n)) ddram_addr <= data_l[6:0];
                            else                                  err        <= 1'b1;
                        end
                        8'b01??????: ;
                        8'b001?????: begin
                            func_dl <= data_l[4];
                            func_n  <= data_l[3];
                            func_f  <= data_l[2];
                        end
                        8'b0001????: begin
                            if (!data_l[3]) ddram_addr <= ac_step(ddram_addr, data_l[2], func_n);
`ifdef LCD_RSP_SHIFT_EN
                            else            shift_ofs  <= ofs_step(shift_ofs, data_l[2]);
`endif
                        end
                        8'b00001???: begin
                            disp_on   <= data_l[2];
                            cursor_on <= data_l[1];
                            blink_on  <= data_l[0];
                        end
                        8'b000001??: begin
                            entry_id <= data_l[1];
                            entry_s  <= data_l[0];
                        end
                        8'b0000001?: begin
                            ddram_addr <= 7'd0;
                            busy_cnt   <= BW'(BUSY_LONG);
`ifdef LCD_RSP_SHIFT_EN
                            shift_ofs  <= 6'd0;
`endif
                        end
                        8'b00000001: begin
                            ddram_addr  <= 7'd0;
                            entry_id    <= 1'b1;
                            fill_active <= 1'b1;
                            fill_idx    <= 7'd0;
                            busy_cnt    <= BW'(BUSY_LONG);
`ifdef LCD_RSP_SHIFT_EN
                            shift_ofs   <= 6'd0;
`endif
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

`ifndef LCD_RSP_SHIFT_EN
    assign shift_ofs = 6'd0;
`endif
endmodule

// File: tb/tb_lcd_panel_responder.sv
// Directed bench for lcd_panel_responder: bus transfers with hand-computed expectations.
// Outputs are sampled on the falling clock edge; every busy wait is bounded.
module tb_lcd_panel_responder;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] ddram_addr;
    logic       disp_on, cursor_on, blink_on, entry_id, entry_s;
    logic       func_dl, func_n, func_f, err;
    logic [5:0] shift_ofs;
    logic [6:0] dbg_addr;
    logic [7:0] dbg_data;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         n;

    lcd_panel_responder_if bus ();

    lcd_panel_responder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .ddram_addr (ddram_addr),
        .disp_on    (disp_on),
        .cursor_on  (cursor_on),
        .blink_on   (blink_on),
        .entry_id   (entry_id),
        .entry_s    (entry_s),
        .func_dl    (func_dl),
        .func_n     (func_n),
        .func_f     (func_f),
        .shift_ofs  (shift_ofs),
        .err        (err),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns at the negedge after the update edge, i.e. where the transfer's effects first show.
    task automatic xfer(input logic rs_i, input logic rw_i, input logic [7:0] d, input int w);
        @(posedge clk); #1;
        bus.e = 1'b1; bus.rs = rs_i; bus.rw = rw_i; bus.lcd_data = d;
        repeat (w) @(posedge clk);
        #1 bus.e = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cmd(input logic [7:0] d);
        xfer(1'b0, 1'b0, d, 2);
    endtask

    task automatic busy_len(output int cnt);
        cnt = 0;
        while (bus.busy_flag && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic peek(input logic [6:0] a, output logic [7:0] d);
        dbg_addr = a; #1; d = dbg_data;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    logic [7:0] pk;

    initial begin
        bus.e = 1'b0; bus.rs = 1'b0; bus.rw = 1'b0; bus.lcd_data = 8'h00;
        dbg_addr = 7'd0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy_flag, 1);
        check("rst_entry_id", entry_id, 1);
        check("rst_ac", ddram_addr, 0);
        check("rst_disp", {disp_on, cursor_on, blink_on, entry_s, func_dl, func_n, func_f}, 0);
        check("rst_err_rdv", {err, bus.rd_valid}, 0);
        check("rst_shift", shift_ofs, 0);

        do_reset();
        busy_len(n);
        check("reset_busy_len", n, 160);
        peek(7'd0, pk);  check("fill_0", pk, 8'h20);
        peek(7'd39, pk); check("fill_39", pk, 8'h20);
        peek(7'd79, pk); check("fill_79", pk, 8'h20);

        cmd(8'h38); busy_len(n); check("fset_busy", n, 40);
        cmd(8'h0E); busy_len(n); check("dctl_busy", n, 40);
        cmd(8'h06); busy_len(n); check("emode_busy", n, 40);
        xfer(1'b1, 1'b0, 8'h41, 2);
        xfer(1'b0, 1'b1, 8'h00, 2);
        check("status_rdv", bus.rd_valid, 1);
        check("status_busy", bus.rd_data, 8'h81);
        @(negedge clk);
        check("rdv_pulse", bus.rd_valid, 0);
        check("rd_hold", bus.rd_data, 8'h81);
        check("func_n", {func_dl, func_n, func_f}, 3'b110);
        check("dctl", {disp_on, cursor_on, blink_on}, 3'b110);
        check("emode", {entry_id, entry_s}, 2'b10);
        check("ac_after_wr", ddram_addr, 7'h01);
        peek(7'd0, pk); check("ddram0", pk, 8'h41);
        busy_len(n);

        cmd(8'h80); busy_len(n);
        xfer(1'b1, 1'b1, 8'h00, 2);
        check("dread", {bus.rd_valid, bus.rd_data}, {1'b1, 8'h41});
        check("dread_ac", ddram_addr, 7'h01);
        check("dread_nobusy", bus.busy_flag, 0);

        cmd(8'hA7); busy_len(n);
        check("ac_27", ddram_addr, 7'h27);
        xfer(1'b1, 1'b0, 8'h5A, 2);
        check("wrap_27_40", ddram_addr, 7'h40);
        peek(7'd39, pk); check("ddram39", pk, 8'h5A);
        busy_len(n);
        cmd(8'hE7); busy_len(n);
        xfer(1'b1, 1'b0, 8'h5B, 2);
        check("wrap_67_00", ddram_addr, 7'h00);
        peek(7'd79, pk); check("ddram79", pk, 8'h5B);
        busy_len(n);
        cmd(8'h10);
        check("curs_left_wrap", ddram_addr, 7'h67);
        busy_len(n);

        cmd(8'h18);
`ifdef LCD_RSP_SHIFT_EN
        check("dshift_left", shift_ofs, 39);
`else
        check("dshift_off", shift_ofs, 0);
`endif
        busy_len(n); check("dshift_busy", n, 40);

        cmd(8'h80); busy_len(n);
        xfer(1'b1, 1'b0, 8'h11, 2);
        xfer(1'b1, 1'b0, 8'h22, 2);
        check("busy_wr_err", err, 1);
        check("busy_wr_ac", ddram_addr, 7'h01);
        peek(7'd1, pk); check("busy_wr_ddram1", pk, 8'h20);
        peek(7'd0, pk); check("ddram0_new", pk, 8'h11);

        do_reset();
        check("rearm_err", err, 0);
        busy_len(n); check("rearm_busy_len", n, 160);
        peek(7'd0, pk); check("refill_0", pk, 8'h20);
        cmd(8'h38); busy_len(n);
        cmd(8'hA8);
        check("illegal_addr_err", err, 1);
        check("illegal_addr_ac", ddram_addr, 7'h00);
        busy_len(n);

        do_reset();
        busy_len(n);
        xfer(1'b1, 1'b0, 8'h77, 1);
        check("short_e_err", err, 1);
        check("short_e_busy", bus.busy_flag, 0);
        check("short_e_ac", ddram_addr, 7'h00);
        peek(7'd0, pk); check("short_e_ddram", pk, 8'h20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
